// File: rtl/mem_tracker_pkg.sv
// rtl/mem_tracker_pkg.sv - shared error codes and saturating counter helper for mem_req_tracker
package mem_tracker_pkg;

  localparam logic [1:0] ERR_MISMATCH   = 2'd0;
  localparam logic [1:0] ERR_UNEXPECTED = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  // Caller passes the counter zero-extended to 64 bits plus its real width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned bits);
    logic [63:0] max_value;
    max_value = (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    return (value >= max_value) ? max_value : value + 64'd1;
  endfunction

endpackage

// File: rtl/tracker_fifo.sv
// rtl/tracker_fifo.sv - circular buffer of outstanding requests {addr, stamp, timed_out}
module tracker_fifo #(
  parameter int ADDR_W  = 20,
  parameter int STAMP_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [STAMP_W-1:0]         push_stamp,
  input  logic                       pop,
  input  logic                       set_timed_out,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [STAMP_W-1:0]         head_stamp,
  output logic                       head_timed_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [ADDR_W-1:0]  addr_d  [DEPTH];
  logic [STAMP_W-1:0] stamp_q [DEPTH];
  logic [STAMP_W-1:0] stamp_d [DEPTH];
  logic [DEPTH-1:0]   to_q, to_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    addr_d  = addr_q;
    stamp_d = stamp_q;
    to_d    = to_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (set_timed_out) to_d[head_q] = 1'b1;
    if (pop) head_d = head_q + PTR_W'(1);
    if (push) begin
      addr_d[tail_q]  = push_addr;
      stamp_d[tail_q] = push_stamp;
      to_d[tail_q]    = 1'b0;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '{default: '0};
      stamp_q <= '{default: '0};
      to_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      stamp_q <= stamp_d;
      to_q    <= to_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_addr      = addr_q[head_q];
  assign head_stamp     = stamp_q[head_q];
  assign head_timed_out = to_q[head_q];
  assign count          = count_q;

endmodule

// File: rtl/mem_req_tracker.sv
// rtl/mem_req_tracker.sv - passive in-order request/response checker with error and latency statistics
module mem_req_tracker
  import mem_tracker_pkg::*;
#(
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 4,
  parameter int LAT_BITS     = 16,
  parameter int COUNT_BITS   = 32,
  parameter int TIMEOUT      = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [ADDRESS_BITS-1:0]  req_addr,
  input  logic                     resp_valid,
  input  logic [ADDRESS_BITS-1:0]  resp_addr,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     full,
  output logic                     empty,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [ADDRESS_BITS-1:0]  err_expected,
  output logic [ADDRESS_BITS-1:0]  err_got,
  output logic [3:0]               err_sticky,
  output logic [COUNT_BITS-1:0]    req_count,
  output logic [COUNT_BITS-1:0]    resp_count,
  output logic [$clog2(DEPTH):0]   max_outstanding,
  output logic [LAT_BITS-1:0]      latency_last,
  output logic [LAT_BITS-1:0]      latency_max
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [LAT_BITS-1:0]     now_q, now_d;
  logic                    err_valid_q, err_valid_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [ADDRESS_BITS-1:0] err_expected_q, err_expected_d;
  logic [ADDRESS_BITS-1:0] err_got_q, err_got_d;
  logic [3:0]              err_sticky_q, err_sticky_d;
  logic [COUNT_BITS-1:0]   req_count_q, req_count_d;
  logic [COUNT_BITS-1:0]   resp_count_q, resp_count_d;
  logic [PW-1:0]           max_out_q, max_out_d;
  logic [LAT_BITS-1:0]     lat_last_q, lat_last_d;
  logic [LAT_BITS-1:0]     lat_max_q, lat_max_d;

  logic [ADDRESS_BITS-1:0] head_addr;
  logic [LAT_BITS-1:0]     head_stamp;
  logic                    head_timed_out;
  logic [PW-1:0]           fifo_count;
  logic                    pop, push, set_to;
  logic                    ev_mis, ev_unexp, ev_ovf, ev_to;
  logic [PW-1:0]           occ_after_pop, occ_next;
  logic [LAT_BITS-1:0]     age;

  tracker_fifo #(
    .ADDR_W  (ADDRESS_BITS),
    .STAMP_W (LAT_BITS),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .push_addr      (req_addr),
    .push_stamp     (now_q),
    .pop            (pop),
    .set_timed_out  (set_to),
    .head_addr      (head_addr),
    .head_stamp     (head_stamp),
    .head_timed_out (head_timed_out),
    .count          (fifo_count)
  );

  always_comb begin
    now_d = now_q + LAT_BITS'(1);
    age   = now_q - head_stamp;

    // Response side first: any response against a non-empty queue consumes the head.
    pop      = resp_valid && (fifo_count != '0);
    ev_mis   = pop && (resp_addr != head_addr);
    ev_unexp = resp_valid && (fifo_count == '0);

    occ_after_pop = fifo_count - PW'(pop);
    push          = req_valid && (occ_after_pop < PW'(DEPTH));
    ev_ovf        = req_valid && !push;
    occ_next      = occ_after_pop + PW'(push);

    ev_to  = (TIMEOUT != 0) && (fifo_count != '0) && !head_timed_out
             && (age >= LAT_BITS'(TIMEOUT));
    // A head popped this cycle must not leave its flag behind for a reused slot.
    set_to = ev_to && !pop;

    err_valid_d    = ev_mis || ev_unexp || ev_ovf || ev_to;
    err_code_d     = '0;
    err_expected_d = '0;
    err_got_d      = '0;
    if (err_valid_d) begin
      err_expected_d = (fifo_count != '0) ? head_addr : '0;
      if (ev_mis) begin
        err_code_d = ERR_MISMATCH;
        err_got_d  = resp_addr;
      end else if (ev_unexp) begin
        err_code_d = ERR_UNEXPECTED;
        err_got_d  = resp_addr;
      end else if (ev_ovf) begin
        err_code_d = ERR_OVERFLOW;
        err_got_d  = req_addr;
      end else begin
        err_code_d = ERR_TIMEOUT;
      end
    end

    err_sticky_d = clear_stats ? 4'b0000 : err_sticky_q;
    err_sticky_d[ERR_MISMATCH]   = err_sticky_d[ERR_MISMATCH]   | ev_mis;
    err_sticky_d[ERR_UNEXPECTED] = err_sticky_d[ERR_UNEXPECTED] | ev_unexp;
    err_sticky_d[ERR_OVERFLOW]   = err_sticky_d[ERR_OVERFLOW]   | ev_ovf;
    err_sticky_d[ERR_TIMEOUT]    = err_sticky_d[ERR_TIMEOUT]    | ev_to;

    req_count_d  = clear_stats ? '0 : req_count_q;
    resp_count_d = clear_stats ? '0 : resp_count_q;
    lat_last_d   = clear_stats ? '0 : lat_last_q;
    lat_max_d    = clear_stats ? '0 : lat_max_q;
    max_out_d    = clear_stats ? '0 : max_out_q;

    if (push) req_count_d = COUNT_BITS'(sat_inc(64'(req_count_d), COUNT_BITS));
    if (resp_valid) resp_count_d = COUNT_BITS'(sat_inc(64'(resp_count_d), COUNT_BITS));
    if (pop && !ev_mis) begin
      lat_last_d = age;
      if (age > lat_max_d) lat_max_d = age;
    end
    if (occ_next > max_out_d) max_out_d = occ_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      now_q          <= '0;
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
      err_expected_q <= '0;
      err_got_q      <= '0;
      err_sticky_q   <= '0;
      req_count_q    <= '0;
      resp_count_q   <= '0;
      max_out_q      <= '0;
      lat_last_q     <= '0;
      lat_max_q      <= '0;
    end else begin
      now_q          <= now_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      err_expected_q <= err_expected_d;
      err_got_q      <= err_got_d;
      err_sticky_q   <= err_sticky_d;
      req_count_q    <= req_count_d;
      resp_count_q   <= resp_count_d;
      max_out_q      <= max_out_d;
      lat_last_q     <= lat_last_d;
      lat_max_q      <= lat_max_d;
    end
  end

  assign outstanding     = fifo_count;
  assign full            = (fifo_count == PW'(DEPTH));
  assign empty           = (fifo_count == '0);
  assign err_valid       = err_valid_q;
  assign err_code        = err_code_q;
  assign err_expected    = err_expected_q;
  assign err_got         = err_got_q;
  assign err_sticky      = err_sticky_q;
  assign req_count       = req_count_q;
  assign resp_count      = resp_count_q;
  assign max_outstanding = max_out_q;
  assign latency_last    = lat_last_q;
  assign latency_max     = lat_max_q;

endmodule
